fifo_n_shared: RTL and testbench

Multi-queue FIFO with one pool of N entries shared dynamically across VQ_N virtual queues. It replaces the fixed per-queue partitioning used by the earlier multi-VQ FIFO: any queue can take any free slot. Each queue is a linked list through a next-pointer array, and free slots are tracked in a bitmap. The block sits between a per-VQ producer and an arbitrated consumer, and reports accept/reject, status and sticky error flags.

---
 rtl/fifo_n_shared_if.sv | 38 +++
 rtl/fifo_n_shared.sv | 125 ++++++++++++
 tb/tb_fifo_n_shared.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_n_shared_if.sv
// Producer/consumer bundle for the shared-pool multi-queue FIFO.
// master drives requests; slave returns accepts, read data and status.
interface fifo_n_shared_if #(
  parameter int N    = 32,
  parameter int VQ_N = 8,
  parameter int W    = 32
);
  localparam int VW = $clog2(VQ_N);
  localparam int CW = $clog2(N + 1);

  logic          push;
  logic [VW-1:0] push_vq;
  logic [W-1:0]  push_data;
  logic          push_accept;
  logic          pop;
  logic [VW-1:0] pop_vq;
  logic          pop_accept;
  logic          pop_data_valid_r;
  logic [VW-1:0] pop_data_vq_r;
  logic [W-1:0]  pop_data_r;
  logic [VQ_N-1:0] empty_r;
  logic          full_r;
  logic [CW-1:0] free_cnt_r;
  logic          err_push_r;
  logic          err_pop_r;

  modport master (
    output push, push_vq, push_data, pop, pop_vq,
    input  push_accept, pop_accept, pop_data_valid_r, pop_data_vq_r, pop_data_r,
           empty_r, full_r, free_cnt_r, err_push_r, err_pop_r
  );

  modport slave (
    input  push, push_vq, push_data, pop, pop_vq,
    output push_accept, pop_accept, pop_data_valid_r, pop_data_vq_r, pop_data_r,
           empty_r, full_r, free_cnt_r, err_push_r, err_pop_r
  );
endinterface

// File: rtl/fifo_n_shared.sv
// Multi-queue FIFO: one pool of N slots shared by VQ_N linked-list queues,
// free slots tracked in a bitmap, lowest free slot allocated first.
module fifo_n_shared #(
  parameter int N    = 32,
  parameter int VQ_N = 8,
  parameter int W    = 32
) (
  input  logic clk,
  input  logic rst,
  fifo_n_shared_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int VW = $clog2(VQ_N);
  localparam int CW = $clog2(N + 1);

  logic [N-1:0]    free_vec_q, free_vec_d;
  logic [W-1:0]    data_q [N];
  logic [IW-1:0]   next_q [N];
  logic [IW-1:0]   head_q [VQ_N];
  logic [IW-1:0]   head_d [VQ_N];
  logic [IW-1:0]   tail_q [VQ_N];
  logic [IW-1:0]   tail_d [VQ_N];
  logic [VQ_N-1:0] empty_q, empty_d;
  logic [CW-1:0]   free_cnt_q, free_cnt_d;
  logic            full_q;
  logic            pop_vld_q;
  logic [VW-1:0]   pop_vq_q;
  logic [W-1:0]    pop_data_q;
  logic            err_push_q, err_pop_q;

  logic            push_acc, pop_acc;
  logic [IW-1:0]   slot;
  logic [IW-1:0]   pop_head;
  logic            link_we;
  logic [IW-1:0]   link_addr;

  assign push_acc = bus.push & (free_cnt_q != '0);
  assign pop_acc  = bus.pop & ~empty_q[bus.pop_vq];
  assign pop_head = head_q[bus.pop_vq];

  // Only registered free bits are candidates, so a slot freed this cycle waits a cycle.
  always_comb begin
    slot = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (free_vec_q[i]) slot = IW'(i);
    end
  end

  always_comb begin
    free_vec_d = free_vec_q;
    empty_d    = empty_q;
    head_d     = head_q;
    tail_d     = tail_q;
    link_we    = 1'b0;
    link_addr  = '0;
    if (pop_acc) begin
      free_vec_d[pop_head] = 1'b1;
      if (pop_head == tail_q[bus.pop_vq]) empty_d[bus.pop_vq] = 1'b1;
      else head_d[bus.pop_vq] = next_q[pop_head];
    end
    // Push sees the queue after any same-cycle pop, so a 1-entry queue relinks cleanly.
    if (push_acc) begin
      free_vec_d[slot] = 1'b0;
      if (empty_d[bus.push_vq]) begin
        head_d[bus.push_vq]  = slot;
        tail_d[bus.push_vq]  = slot;
        empty_d[bus.push_vq] = 1'b0;
      end else begin
        link_we             = 1'b1;
        link_addr           = tail_d[bus.push_vq];
        tail_d[bus.push_vq] = slot;
      end
    end
  end

  assign free_cnt_d = free_cnt_q - CW'(push_acc) + CW'(pop_acc);

  always_ff @(posedge clk) begin
    if (push_acc) data_q[slot] <= bus.push_data;
    if (link_we)  next_q[link_addr] <= slot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      free_vec_q <= '1;
      empty_q    <= '1;
      free_cnt_q <= CW'(N);
      full_q     <= 1'b0;
      pop_vld_q  <= 1'b0;
      pop_vq_q   <= '0;
      pop_data_q <= '0;
      err_push_q <= 1'b0;
      err_pop_q  <= 1'b0;
      for (int v = 0; v < VQ_N; v++) begin
        head_q[v] <= '0;
        tail_q[v] <= '0;
      end
    end else begin
      free_vec_q <= free_vec_d;
      empty_q    <= empty_d;
      free_cnt_q <= free_cnt_d;
      full_q     <= (free_cnt_d == '0);
      head_q     <= head_d;
      tail_q     <= tail_d;
      pop_vld_q  <= pop_acc;
      if (pop_acc) begin
        pop_vq_q   <= bus.pop_vq;
        pop_data_q <= data_q[pop_head];
      end
      if (bus.push & ~push_acc) err_push_q <= 1'b1;
      if (bus.pop & ~pop_acc)   err_pop_q  <= 1'b1;
    end
  end

  assign bus.push_accept      = push_acc;
  assign bus.pop_accept       = pop_acc;
  assign bus.pop_data_valid_r = pop_vld_q;
  assign bus.pop_data_vq_r    = pop_vq_q;
  assign bus.pop_data_r       = pop_data_q;
  assign bus.empty_r          = empty_q;
  assign bus.full_r           = full_q;
  assign bus.free_cnt_r       = free_cnt_q;
  assign bus.err_push_r       = err_push_q;
  assign bus.err_pop_r        = err_pop_q;
endmodule

// File: tb/tb_fifo_n_shared.sv
// Bench for fifo_n_shared (N=4, VQ_N=2, W=8): directed scenarios plus a random
// run checked against a per-queue FIFO model of the pool.
module tb_fifo_n_shared;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_n_shared_if #(.N(4), .VQ_N(2), .W(8)) bus ();
  fifo_n_shared #(.N(4), .VQ_N(2), .W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  logic [7:0] mq [2][$];
  logic exp_pa, exp_oa, exp_valid, exp_errp, exp_erro;
  logic [0:0] exp_vq;
  logic [7:0] exp_data;
  logic acc_push, acc_pop;

  function automatic int used();
    return mq[0].size() + mq[1].size();
  endfunction

  task automatic model_reset();
    mq[0].delete(); mq[1].delete();
    exp_valid = 0; exp_vq = 0; exp_data = 0; exp_errp = 0; exp_erro = 0;
  endtask

  task automatic do_reset();
    rst = 1; bus.push = 1; bus.push_vq = 0; bus.push_data = 8'hEE; bus.pop = 1; bus.pop_vq = 1;
    @(posedge clk); #1;
    rst = 0; bus.push = 0; bus.pop = 0;
    model_reset();
  endtask

  // One cycle of requests; the model pops before it pushes, as a queue would.
  task automatic drive(input logic p, input logic pvq, input logic [7:0] pd,
                       input logic o, input logic ovq);
    bus.push = p; bus.push_vq = pvq; bus.push_data = pd; bus.pop = o; bus.pop_vq = ovq;
    #1;
    acc_push = bus.push_accept; acc_pop = bus.pop_accept;
    exp_pa = p && (used() < 4);
    exp_oa = o && (mq[ovq].size() != 0);
    exp_valid = exp_oa;
    if (exp_oa) begin exp_data = mq[ovq].pop_front(); exp_vq = ovq; end
    if (exp_pa) mq[pvq].push_back(pd);
    if (p && !exp_pa) exp_errp = 1;
    if (o && !exp_oa) exp_erro = 1;
    @(posedge clk); #1;
    bus.push = 0; bus.pop = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.empty_r !== 2'b11) begin failures++; $display("FAIL reset_empty got=%b exp=11", bus.empty_r); end
    checks++; if (bus.full_r !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.full_r); end
    checks++; if (bus.free_cnt_r !== 3'd4) begin failures++; $display("FAIL reset_free got=%0d exp=4", bus.free_cnt_r); end
    checks++; if (bus.pop_data_valid_r !== 1'b0 || bus.pop_data_r !== 8'h00 || bus.pop_data_vq_r !== 1'b0) begin
      failures++; $display("FAIL reset_popdata got=%b/%h/%b exp=0/00/0", bus.pop_data_valid_r, bus.pop_data_r, bus.pop_data_vq_r); end
    checks++; if (bus.err_push_r !== 1'b0 || bus.err_pop_r !== 1'b0) begin
      failures++; $display("FAIL reset_err got=%b%b exp=00", bus.err_push_r, bus.err_pop_r); end
  endtask

  task automatic test_interleave();
    drive(1, 0, 8'hA1, 0, 0);
    checks++; if (bus.empty_r !== 2'b10) begin failures++; $display("FAIL il_empty_after_push got=%b exp=10", bus.empty_r); end
    drive(1, 1, 8'hB1, 0, 0);
    drive(1, 0, 8'hA2, 0, 0);
    checks++; if (bus.free_cnt_r !== 3'd1) begin failures++; $display("FAIL il_free got=%0d exp=1", bus.free_cnt_r); end
    drive(0, 0, 0, 1, 0);
    checks++; if (bus.pop_data_valid_r !== 1 || bus.pop_data_r !== 8'hA1 || bus.pop_data_vq_r !== 0) begin
      failures++; $display("FAIL il_pop1 got=%b/%h/%b exp=1/a1/0", bus.pop_data_valid_r, bus.pop_data_r, bus.pop_data_vq_r); end
    drive(0, 0, 0, 1, 0);
    checks++; if (bus.pop_data_valid_r !== 1 || bus.pop_data_r !== 8'hA2 || bus.pop_data_vq_r !== 0) begin
      failures++; $display("FAIL il_pop2 got=%b/%h/%b exp=1/a2/0", bus.pop_data_valid_r, bus.pop_data_r, bus.pop_data_vq_r); end
    checks++; if (bus.empty_r !== 2'b01) begin failures++; $display("FAIL il_empty got=%b exp=01", bus.empty_r); end
    drive(0, 0, 0, 1, 1);
    checks++; if (bus.pop_data_valid_r !== 1 || bus.pop_data_r !== 8'hB1 || bus.pop_data_vq_r !== 1) begin
      failures++; $display("FAIL il_pop_vq1 got=%b/%h/%b exp=1/b1/1", bus.pop_data_valid_r, bus.pop_data_r, bus.pop_data_vq_r); end
    drive(0, 0, 0, 0, 0);
    checks++; if (bus.pop_data_valid_r !== 0 || bus.pop_data_r !== 8'hB1) begin
      failures++; $display("FAIL il_hold got=%b/%h exp=0/b1", bus.pop_data_valid_r, bus.pop_data_r); end
  endtask

  task automatic test_full();
    for (int i = 1; i <= 4; i++) drive(1, 1, 8'(i), 0, 0);
    checks++; if (bus.full_r !== 1 || bus.free_cnt_r !== 3'd0) begin
      failures++; $display("FAIL full_state got=%b/%0d exp=1/0", bus.full_r, bus.free_cnt_r); end
    checks++; if (bus.err_push_r !== 0) begin failures++; $display("FAIL full_no_err got=%b exp=0", bus.err_push_r); end
    drive(1, 1, 8'h05, 0, 0);
    checks++; if (acc_push !== 0 || bus.err_push_r !== 1) begin
      failures++; $display("FAIL full_reject got=%b/%b exp=0/1", acc_push, bus.err_push_r); end
    drive(1, 0, 8'h77, 1, 1);
    checks++; if (acc_pop !== 1 || acc_push !== 0) begin
      failures++; $display("FAIL full_pushpop_acc got=%b/%b exp=1/0", acc_pop, acc_push); end
    checks++; if (bus.pop_data_r !== 8'h01 || bus.free_cnt_r !== 3'd1 || bus.full_r !== 0 || bus.empty_r !== 2'b01) begin
      failures++; $display("FAIL full_pushpop_res got=%h/%0d/%b/%b exp=01/1/0/01", bus.pop_data_r, bus.free_cnt_r, bus.full_r, bus.empty_r); end
    for (int i = 2; i <= 4; i++) begin
      drive(0, 0, 0, 1, 1);
      checks++; if (bus.pop_data_valid_r !== 1 || bus.pop_data_r !== 8'(i)) begin
        failures++; $display("FAIL full_drain got=%b/%h exp=1/%h", bus.pop_data_valid_r, bus.pop_data_r, 8'(i)); end
    end
  endtask

  task automatic test_underflow();
    do_reset();
    drive(0, 0, 0, 1, 0);
    checks++; if (acc_pop !== 0 || bus.pop_data_valid_r !== 0) begin
      failures++; $display("FAIL under_acc got=%b/%b exp=0/0", acc_pop, bus.pop_data_valid_r); end
    checks++; if (bus.err_pop_r !== 1 || bus.free_cnt_r !== 3'd4 || bus.empty_r !== 2'b11) begin
      failures++; $display("FAIL under_state got=%b/%0d/%b exp=1/4/11", bus.err_pop_r, bus.free_cnt_r, bus.empty_r); end
  endtask

  task automatic test_same_queue();
    do_reset();
    drive(1, 0, 8'h11, 0, 0);
    drive(1, 0, 8'h22, 1, 0);
    checks++; if (bus.pop_data_r !== 8'h11 || bus.empty_r[0] !== 0 || bus.free_cnt_r !== 3'd3) begin
      failures++; $display("FAIL same_swap got=%h/%b/%0d exp=11/0/3", bus.pop_data_r, bus.empty_r[0], bus.free_cnt_r); end
    drive(0, 0, 0, 1, 0);
    checks++; if (bus.pop_data_valid_r !== 1 || bus.pop_data_r !== 8'h22 || bus.empty_r !== 2'b11) begin
      failures++; $display("FAIL same_second got=%b/%h/%b exp=1/22/11", bus.pop_data_valid_r, bus.pop_data_r, bus.empty_r); end
    drive(1, 1, 8'h33, 1, 1);
    checks++; if (acc_pop !== 0 || acc_push !== 1 || bus.empty_r !== 2'b01) begin
      failures++; $display("FAIL same_empty got=%b/%b/%b exp=0/1/01", acc_pop, acc_push, bus.empty_r); end
    drive(0, 0, 0, 1, 1);
    checks++; if (bus.pop_data_r !== 8'h33 || bus.pop_data_vq_r !== 1) begin
      failures++; $display("FAIL same_empty_pop got=%h/%b exp=33/1", bus.pop_data_r, bus.pop_data_vq_r); end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 8'hC1, 0, 0);
    drive(1, 1, 8'hC2, 0, 0);
    drive(1, 0, 8'hC3, 1, 1);
    do_reset();
    checks++; if (bus.empty_r !== 2'b11 || bus.free_cnt_r !== 3'd4 || bus.full_r !== 0) begin
      failures++; $display("FAIL mid_state got=%b/%0d/%b exp=11/4/0", bus.empty_r, bus.free_cnt_r, bus.full_r); end
    checks++; if (bus.pop_data_valid_r !== 0 || bus.pop_data_r !== 0 || bus.err_pop_r !== 0 || bus.err_push_r !== 0) begin
      failures++; $display("FAIL mid_outs got=%b/%h/%b/%b exp=0/00/0/0", bus.pop_data_valid_r, bus.pop_data_r, bus.err_pop_r, bus.err_push_r); end
    drive(1, 0, 8'h55, 0, 0);
    drive(0, 0, 0, 1, 0);
    checks++; if (bus.pop_data_valid_r !== 1 || bus.pop_data_r !== 8'h55 || bus.empty_r !== 2'b11) begin
      failures++; $display("FAIL mid_55 got=%b/%h/%b exp=1/55/11", bus.pop_data_valid_r, bus.pop_data_r, bus.empty_r); end
  endtask

  task automatic test_random();
    logic [1:0] exp_empty;
    int bad;
    do_reset();
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 99) < 60), 1'($urandom), 8'($urandom),
            ($urandom_range(0, 99) < 50), 1'($urandom));
      exp_empty = {mq[1].size() == 0, mq[0].size() == 0};
      checks++;
      if (acc_push !== exp_pa || acc_pop !== exp_oa || bus.pop_data_valid_r !== exp_valid ||
          bus.pop_data_r !== exp_data || bus.pop_data_vq_r !== exp_vq || bus.empty_r !== exp_empty ||
          bus.free_cnt_r !== 3'(4 - used()) || bus.full_r !== (used() == 4) ||
          bus.err_push_r !== exp_errp || bus.err_pop_r !== exp_erro) begin
        failures++;
        if (bad < 5)
          $display("FAIL random_c%0d got acc=%b%b v=%b d=%h vq=%b e=%b f=%0d err=%b%b exp acc=%b%b v=%b d=%h vq=%b e=%b f=%0d err=%b%b",
                   c, acc_push, acc_pop, bus.pop_data_valid_r, bus.pop_data_r, bus.pop_data_vq_r, bus.empty_r,
                   bus.free_cnt_r, bus.err_push_r, bus.err_pop_r, exp_pa, exp_oa, exp_valid, exp_data, exp_vq,
                   exp_empty, 4 - used(), exp_errp, exp_erro);
        bad++;
      end
    end
  endtask

  initial begin
    bus.push = 0; bus.push_vq = 0; bus.push_data = 0; bus.pop = 0; bus.pop_vq = 0;
    #2;
    test_reset();
    test_interleave();
    test_full();
    test_underflow();
    test_same_queue();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
